// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int WS_W = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard/display MMIO registers and their read mux.
module lc3_mmio_regs import lc3_mem_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        kb_valid,
  input  logic [7:0]  kb_char,
  input  logic        disp_ready,
  input  logic        ddr_wr,
  input  logic        kbdr_rd,
  input  logic [7:0]  wdata,
  input  logic [15:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        disp_valid,
  output logic [7:0]  disp_char
);

  logic       kb_ready;
  logic [7:0] kbdr;

  // A KBDR read frees the slot on the same edge, so a coincident char lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      kb_ready <= 1'b0;
      kbdr     <= '0;
    end else if (kb_valid && (!kb_ready || kbdr_rd)) begin
      kbdr     <= kb_char;
      kb_ready <= 1'b1;
    end else if (kbdr_rd) begin
      kb_ready <= 1'b0;
    end
  end

  // Handshake wins over a same-edge DDR write, which is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid <= 1'b0;
      disp_char  <= '0;
    end else if (disp_valid && disp_ready) begin
      disp_valid <= 1'b0;
    end else if (ddr_wr && !disp_valid) begin
      disp_char  <= wdata;
      disp_valid <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      KBSR_ADDR: rd_data = {kb_ready, 15'b0};
      KBDR_ADDR: rd_data = {8'b0, kbdr};
      DSR_ADDR:  rd_data = {~disp_valid, 15'b0};
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: word RAM + keyboard/display MMIO behind a wait-state FSM.
module lc3_mem_responder import lc3_mem_pkg::*; #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        ACK,
  output logic        BUSY,
  input  logic        KB_VALID,
  input  logic [7:0]  KB_CHAR,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_CHAR,
  input  logic        DISP_READY
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t          state;
  logic [WS_W-1:0] ws_cnt;
  mem_req_t        req_q;
  logic [15:0]     mem [MEM_DEPTH];
  logic [15:0]     mmio_rd;
  logic [15:0]     rd_mux;
  logic            commit;
  logic            in_ram;

  // Commit happens on the edge that ends RESP; a reset on that edge aborts it.
  assign commit = (state == RESP) && !RESET;
  assign in_ram = {1'b0, req_q.addr} < 17'(MEM_DEPTH);
  assign rd_mux = in_ram ? mem[req_q.addr[AW-1:0]] : mmio_rd;
  assign BUSY   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (commit && req_q.we && in_ram)
      mem[req_q.addr[AW-1:0]] <= req_q.wdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      ws_cnt <= '0;
      req_q  <= '0;
      ACK    <= 1'b0;
      RDATA  <= '0;
    end else begin
      ACK <= 1'b0;
      case (state)
        IDLE: if (REQ) begin
          req_q <= '{we: WE, addr: ADDR, wdata: WDATA};
          if (WAIT_STATES == 0) begin
            state <= RESP;
          end else begin
            state  <= WAIT;
            ws_cnt <= WS_W'(WAIT_STATES - 1);
          end
        end
        WAIT: begin
          if (ws_cnt == '0) state <= RESP;
          else              ws_cnt <= ws_cnt - 1'b1;
        end
        RESP: begin
          state <= IDLE;
          ACK   <= 1'b1;
          if (!req_q.we) RDATA <= rd_mux;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lc3_mmio_regs u_mmio (
    .clk        (CLK),
    .reset      (RESET),
    .kb_valid   (KB_VALID),
    .kb_char    (KB_CHAR),
    .disp_ready (DISP_READY),
    .ddr_wr     (commit && req_q.we && (req_q.addr == DDR_ADDR)),
    .kbdr_rd    (commit && !req_q.we && (req_q.addr == KBDR_ADDR)),
    .wdata      (req_q.wdata[7:0]),
    .rd_addr    (req_q.addr),
    .rd_data    (mmio_rd),
    .disp_valid (DISP_VALID),
    .disp_char  (DISP_CHAR)
  );

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed scoreboard bench for lc3_mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_lc3_mem_responder;

  localparam int WS = 2;

  logic        CLK = 1'b0;
  logic        RESET, REQ, WE, KB_VALID, DISP_READY;
  logic [15:0] ADDR, WDATA, RDATA;
  logic        ACK, BUSY, DISP_VALID;
  logic [7:0]  KB_CHAR, DISP_CHAR;

  logic        REQ0, WE0, ACK0, BUSY0, DISP_VALID0;
  logic [15:0] ADDR0, WDATA0, RDATA0;
  logic [7:0]  DISP_CHAR0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  lc3_mem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(WS)) u_dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .ACK(ACK), .BUSY(BUSY), .KB_VALID(KB_VALID), .KB_CHAR(KB_CHAR),
    .DISP_VALID(DISP_VALID), .DISP_CHAR(DISP_CHAR), .DISP_READY(DISP_READY)
  );

  lc3_mem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ0), .WE(WE0), .ADDR(ADDR0), .WDATA(WDATA0),
    .RDATA(RDATA0), .ACK(ACK0), .BUSY(BUSY0), .KB_VALID(1'b0), .KB_CHAR(8'h00),
    .DISP_VALID(DISP_VALID0), .DISP_CHAR(DISP_CHAR0), .DISP_READY(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on u_dut; optionally strobes a keyboard char during the RESP cycle.
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input logic kb_en, input logic [7:0] kb_c);
    int n, busy_n;
    logic [15:0] e;
    @(negedge CLK);
    REQ = 1'b1; WE = we; ADDR = a; WDATA = d;
    if (!we) exp_q.push_back(exp);
    @(posedge CLK); #1;
    REQ = 1'b0; WE = ~we; ADDR = 16'hFFFF; WDATA = 16'hDEAD;
    n = 0; busy_n = 0;
    while (!ACK && n < 20) begin
      if (BUSY) busy_n++;
      if (kb_en && n == WS) begin KB_VALID = 1'b1; KB_CHAR = kb_c; end
      @(posedge CLK); #1;
      KB_VALID = 1'b0;
      n++;
    end
    chk("ack_latency", n, WS + 1);
    chk("busy_cycles", busy_n, WS + 1);
    chk("busy_at_ack", BUSY, 0);
    if (!we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdata", RDATA, e);
    end
    @(posedge CLK); #1;
    chk("ack_single", ACK, 0);
    WE = 1'b0;
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge CLK); KB_VALID = 1'b1; KB_CHAR = c;
    @(negedge CLK); KB_VALID = 1'b0;
  endtask

  initial begin
    int ack_seen;
    logic [15:0] e;
    RESET = 1'b1; REQ = 0; WE = 0; ADDR = 0; WDATA = 0; KB_VALID = 0; KB_CHAR = 0;
    DISP_READY = 0; REQ0 = 0; WE0 = 0; ADDR0 = 0; WDATA0 = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_disp_valid", DISP_VALID, 0);
    chk("rst_disp_char", DISP_CHAR, 0);
    RESET = 1'b0;

    // RAM write/read with wait states
    access(1, 16'h0010, 16'h1234, 0, 0, 0);
    access(0, 16'h0010, 0, 16'h1234, 0, 0);
    access(0, 16'h8000, 0, 16'h0000, 0, 0);

    // Keyboard
    access(0, 16'hFE00, 0, 16'h0000, 0, 0);
    kb_pulse(8'h41);
    access(0, 16'hFE00, 0, 16'h8000, 0, 0);
    access(0, 16'hFE02, 0, 16'h0041, 0, 0);
    access(0, 16'hFE00, 0, 16'h0000, 0, 0);
    kb_pulse(8'h41);
    kb_pulse(8'h42);
    access(0, 16'hFE02, 0, 16'h0041, 1, 8'h43);
    access(0, 16'hFE00, 0, 16'h8000, 0, 0);
    access(0, 16'hFE02, 0, 16'h0043, 0, 0);
    access(0, 16'hFE00, 0, 16'h0000, 0, 0);

    // Display
    access(1, 16'hFE06, 16'h0058, 0, 0, 0);
    chk("disp_valid_set", DISP_VALID, 1);
    chk("disp_char", DISP_CHAR, 8'h58);
    access(0, 16'hFE04, 0, 16'h0000, 0, 0);
    access(1, 16'hFE06, 16'h0059, 0, 0, 0);
    chk("disp_char_kept", DISP_CHAR, 8'h58);
    @(negedge CLK); DISP_READY = 1'b1;
    @(posedge CLK); #1;
    chk("disp_valid_clr", DISP_VALID, 0);
    DISP_READY = 1'b0;
    access(0, 16'hFE04, 0, 16'h8000, 0, 0);
    access(0, 16'hFE06, 0, 16'h0000, 0, 0);

    // Reset in WAIT aborts the write
    access(1, 16'h0020, 16'h1111, 0, 0, 0);
    access(1, 16'hFE06, 16'h005A, 0, 0, 0);
    kb_pulse(8'h55);
    access(0, 16'h0020, 0, 16'h1111, 0, 0);
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; ADDR = 16'h0020; WDATA = 16'hBEEF;
    @(posedge CLK); #1;
    REQ = 1'b0; WE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (ACK) ack_seen++;
      if (i == 1) RESET = 1'b0;
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_rdata", RDATA, 0);
    chk("abort_disp_valid", DISP_VALID, 0);
    chk("abort_disp_char", DISP_CHAR, 0);
    access(0, 16'h0020, 0, 16'h1111, 0, 0);
    access(0, 16'hFE00, 0, 16'h0000, 0, 0);
    access(0, 16'hFE02, 0, 16'h0000, 0, 0);
    access(0, 16'hFE04, 0, 16'h8000, 0, 0);

    // WAIT_STATES=0 with REQ held: write, then reads, ACK every other cycle
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    @(negedge CLK);
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 16'h0005; WDATA0 = 16'hABCD;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      chk("ws0_ack_pattern", ACK0, (k % 2 == 1) ? 1 : 0);
      if (ACK0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ws0_rdata", RDATA0, e);
      end
      if (k == 0) WE0 = 1'b0;
      if (k == 2) ADDR0 = 16'h8000;
    end
    REQ0 = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
